// File: rtl/sisc_ctrl_mc_if.sv
// Control bus between the SISC multi-cycle sequencer and the IR/status/datapath side.
interface sisc_ctrl_mc_if #(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned CC_W  = 4
);
  logic [OPC_W-1:0] opcode;
  logic [CC_W-1:0]  mm;
  logic [CC_W-1:0]  stat;
  logic             mem_ready;
  logic             ir_load;
  logic             pc_write;
  logic             pc_sel;
  logic             pc_rel;
  logic [1:0]       alu_op;
  logic             mem_re;
  logic             mem_we;
  logic             rf_we;
  logic             wb_sel;
  logic             halted;
  logic             mem_err;

  modport master (
    input  opcode, mm, stat, mem_ready,
    output ir_load, pc_write, pc_sel, pc_rel, alu_op,
           mem_re, mem_we, rf_we, wb_sel, halted, mem_err
  );

  modport slave (
    output opcode, mm, stat, mem_ready,
    input  ir_load, pc_write, pc_sel, pc_rel, alu_op,
           mem_re, mem_we, rf_we, wb_sel, halted, mem_err
  );
endinterface

// File: rtl/sisc_ctrl_mc.sv
// SISC multi-cycle control FSM: fetch/decode/execute/mem/writeback with ready-stretched MEM and timeout.
// Optional SISC_MEM_SKIP_EN: non-memory opcodes bypass MEM (4-cycle instruction).
module sisc_ctrl_mc #(
  parameter int unsigned    OPC_W  = 4,
  parameter int unsigned    CC_W   = 4,
  parameter int unsigned    WAIT_W = 4,
  parameter logic [CC_W-1:0] AM_IMM = CC_W'(8)
) (
  input logic            clk,
  input logic            rst_f,
  sisc_ctrl_mc_if.master bus
);

  localparam logic [OPC_W-1:0] OP_LOD = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STR = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SWP = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_BRA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_BRR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_BNE = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_BNR = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_ALU = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

  // Last count value before the limit: a miss here means the limit is reached this edge.
  localparam logic [WAIT_W-1:0] CNT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;

  logic is_lod, is_str, is_mem, is_alu, is_swp, is_hlt;
  logic is_br_set, is_br_clr, is_rel, flag_hit, br_taken;

  assign is_lod    = (bus.opcode == OP_LOD);
  assign is_str    = (bus.opcode == OP_STR);
  assign is_mem    = is_lod | is_str;
  assign is_alu    = (bus.opcode == OP_ALU);
  assign is_swp    = (bus.opcode == OP_SWP);
  assign is_hlt    = (bus.opcode == OP_HLT);
  assign is_br_set = (bus.opcode == OP_BRA) | (bus.opcode == OP_BRR);
  assign is_br_clr = (bus.opcode == OP_BNE) | (bus.opcode == OP_BNR);
  assign is_rel    = (bus.opcode == OP_BRR) | (bus.opcode == OP_BNR);
  assign flag_hit  = |(bus.stat & bus.mm);
  assign br_taken  = (is_br_set & flag_hit) | (is_br_clr & ~flag_hit);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= S_START;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        S_START:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= is_hlt ? S_HALT : S_EXECUTE;
        S_EXECUTE: begin
          wait_cnt <= '0;
`ifdef SISC_MEM_SKIP_EN
          state <= is_mem ? S_MEM : S_WRITEBACK;
`else
          state <= S_MEM;
`endif
        end
        S_MEM: begin
          if (!is_mem || bus.mem_ready) begin
            state <= S_WRITEBACK;
          end else if (wait_cnt == CNT_LAST) begin
            mem_err_q <= 1'b1;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_START;
      endcase
    end
  end

  logic       ir_load_c, pc_write_c, pc_sel_c, pc_rel_c;
  logic [1:0] alu_op_c;
  logic       mem_re_c, mem_we_c, rf_we_c, wb_sel_c, halted_c;

  always_comb begin
    ir_load_c  = 1'b0;
    pc_write_c = 1'b0;
    pc_sel_c   = 1'b0;
    pc_rel_c   = 1'b0;
    alu_op_c   = 2'b00;
    mem_re_c   = 1'b0;
    mem_we_c   = 1'b0;
    rf_we_c    = 1'b0;
    wb_sel_c   = 1'b0;
    halted_c   = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load_c  = 1'b1;
        pc_write_c = 1'b1;
      end
      S_EXECUTE: begin
        if (is_alu) alu_op_c = {1'b0, (bus.mm == AM_IMM)};
        if (is_mem) alu_op_c = 2'b10;
        if (br_taken) begin
          pc_write_c = 1'b1;
          pc_sel_c   = 1'b1;
          pc_rel_c   = is_rel;
        end
      end
      S_MEM: begin
        mem_re_c = is_lod & ~mem_err_q;
        mem_we_c = is_str & ~mem_err_q;
      end
      S_WRITEBACK: begin
        rf_we_c  = is_alu | is_lod | is_swp;
        wb_sel_c = is_lod;
      end
      S_HALT:  halted_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.ir_load  = ir_load_c;
  assign bus.pc_write = pc_write_c;
  assign bus.pc_sel   = pc_sel_c;
  assign bus.pc_rel   = pc_rel_c;
  assign bus.alu_op   = alu_op_c;
  assign bus.mem_re   = mem_re_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.rf_we    = rf_we_c;
  assign bus.wb_sel   = wb_sel_c;
  assign bus.halted   = halted_c;
  assign bus.mem_err  = mem_err_q;

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: directed vector table, hand-written corner sequences, and
// randomized instruction streams against a per-instruction expected-trace model.
module tb_sisc_ctrl_mc;

`ifdef SISC_MEM_SKIP_EN
  localparam int unsigned NM_LEN = 4;
`else
  localparam int unsigned NM_LEN = 5;
`endif

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  always #5 clk = ~clk;

  sisc_ctrl_mc_if #(.OPC_W(4), .CC_W(4)) bus ();

  sisc_ctrl_mc #(.OPC_W(4), .CC_W(4), .WAIT_W(4), .AM_IMM(4'd8)) dut (
    .clk  (clk),
    .rst_f(rst_f),
    .bus  (bus)
  );

  // {ir_load,pc_write,pc_sel,pc_rel,alu_op[1:0],mem_re,mem_we,rf_we,wb_sel,halted,mem_err}
  logic [11:0] outv;
  assign outv = {bus.ir_load, bus.pc_write, bus.pc_sel, bus.pc_rel, bus.alu_op,
                 bus.mem_re, bus.mem_we, bus.rf_we, bus.wb_sel, bus.halted, bus.mem_err};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cycle(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                           input logic rdy, output logic [11:0] v);
    @(posedge clk);
    #1;
    bus.opcode    = op;
    bus.mm        = mm;
    bus.stat      = st;
    bus.mem_ready = rdy;
    @(negedge clk);
    v = outv;
  endtask

  task automatic reset_task(input string name);
    rst_f = 1'b0;
    #1;
    check(name, {20'd0, outv}, 32'd0);
    @(negedge clk);
    #1 rst_f = 1'b1;
  endtask

  // ---------------- reference model: expected per-cycle trace of one instruction
  typedef struct {
    logic [3:0]  op, mm, st;
    logic        rdy;
    logic [11:0] exp;
  } cyc_t;
  cyc_t q[$];

  function automatic logic [11:0] exec_exp(input logic [3:0] op, input logic [3:0] mm,
                                           input logic [3:0] st);
    logic taken;
    taken = 1'b0;
    if (op == 4'd8) return {6'b0, (mm == 4'd8), 6'b0};
    if (op == 4'd1 || op == 4'd2) return 12'h080;
    if (op == 4'd4 || op == 4'd5) taken = ((st & mm) != 4'd0);
    if (op == 4'd6 || op == 4'd7) taken = ((st & mm) == 4'd0);
    if (taken) return {1'b0, 1'b1, 1'b1, (op == 4'd5 || op == 4'd7), 8'b0};
    return 12'h000;
  endfunction

  task automatic push(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                      input logic rdy, input logic [11:0] exp);
    cyc_t c;
    c.op = op; c.mm = mm; c.st = st; c.rdy = rdy; c.exp = exp;
    q.push_back(c);
  endtask

  task automatic gen_instr(input logic [3:0] op, input logic [3:0] mm, input int unsigned k,
                           output bit halts);
    logic [3:0]  st;
    logic [11:0] strobe;
    halts = 1'b0;
    push(op, mm, 4'($urandom), 1'($urandom), 12'hC00);
    push(op, mm, 4'($urandom), 1'($urandom), 12'h000);
    if (op == 4'd15) begin
      repeat (4) push(op, mm, 4'($urandom), 1'($urandom), 12'h002);
      halts = 1'b1;
      return;
    end
    st = 4'($urandom);
    push(op, mm, st, 1'($urandom), exec_exp(op, mm, st));
    if (op == 4'd1 || op == 4'd2) begin
      strobe = (op == 4'd1) ? 12'h020 : 12'h010;
      if (k < 15) begin
        for (int unsigned i = 0; i < k; i++) push(op, mm, 4'($urandom), 1'b0, strobe);
        push(op, mm, 4'($urandom), 1'b1, strobe);
      end else begin
        for (int unsigned i = 0; i < 15; i++) push(op, mm, 4'($urandom), 1'b0, strobe);
        repeat (4) push(op, mm, 4'($urandom), 1'($urandom), 12'h003);
        halts = 1'b1;
        return;
      end
    end else begin
`ifndef SISC_MEM_SKIP_EN
      push(op, mm, 4'($urandom), 1'($urandom), 12'h000);
`endif
    end
    push(op, mm, 4'($urandom), 1'($urandom),
         {8'b0, (op == 4'd8 || op == 4'd1 || op == 4'd3), (op == 4'd1), 2'b0});
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic [3:0]  op, mm, st;
    int unsigned k;
    logic [11:0] exec, wb;
    int unsigned len, memc;
  } vec_t;
  vec_t tbl[13];

  initial begin
    logic [11:0] v, prev, ex;
    int unsigned cyc, memc, n;
    bit done, halts;
    logic [3:0] op, mm;
    int unsigned k, r;

    bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_ready = 1'b0;

    tbl[0]  = '{4'd8, 4'd8, 4'd0, 0,  12'h040, 12'h008, NM_LEN, 0};
    tbl[1]  = '{4'd8, 4'd3, 4'd0, 0,  12'h000, 12'h008, NM_LEN, 0};
    tbl[2]  = '{4'd5, 4'd2, 4'd2, 0,  12'h700, 12'h000, NM_LEN, 0};
    tbl[3]  = '{4'd6, 4'd2, 4'd2, 0,  12'h000, 12'h000, NM_LEN, 0};
    tbl[4]  = '{4'd6, 4'd2, 4'd0, 0,  12'h600, 12'h000, NM_LEN, 0};
    tbl[5]  = '{4'd4, 4'd3, 4'd4, 0,  12'h000, 12'h000, NM_LEN, 0};
    tbl[6]  = '{4'd7, 4'd2, 4'd1, 0,  12'h700, 12'h000, NM_LEN, 0};
    tbl[7]  = '{4'd1, 4'd0, 4'd0, 3,  12'h080, 12'h00C, 8,      4};
    tbl[8]  = '{4'd2, 4'd0, 4'd0, 0,  12'h080, 12'h000, 5,      1};
    tbl[9]  = '{4'd3, 4'd0, 4'd0, 0,  12'h000, 12'h008, NM_LEN, 0};
    tbl[10] = '{4'd0, 4'd0, 4'd0, 0,  12'h000, 12'h000, NM_LEN, 0};
    tbl[11] = '{4'd11, 4'd8, 4'd0, 0, 12'h000, 12'h000, NM_LEN, 0};
    tbl[12] = '{4'd1, 4'd0, 4'd0, 14, 12'h080, 12'h00C, 19,     15};

    #2 reset_task("rst_init");

    run_cycle(4'd0, 4'd0, 4'd0, 1'b0, v);
    check("fetch_after_reset", {20'd0, v}, 32'hC00);

    foreach (tbl[i]) begin
      prev = v; ex = '0; cyc = 1; memc = 0; done = 1'b0;
      while (!done && cyc < 40) begin
        run_cycle(tbl[i].op, tbl[i].mm, tbl[i].st, (cyc >= 3) && (cyc - 3 >= tbl[i].k), v);
        if (cyc == 2) ex = v;
        if (v[5] | v[4]) memc++;
        if (v[11]) done = 1'b1;
        else begin
          prev = v;
          cyc++;
        end
      end
      if (!done) begin
        check("dir_next_fetch", 32'd0, 32'd1);
        reset_task("rst_dir_recover");
        run_cycle(4'd0, 4'd0, 4'd0, 1'b0, v);
      end else begin
        check($sformatf("dir%0d_exec", i), {20'd0, ex}, {20'd0, tbl[i].exec});
        check($sformatf("dir%0d_wb", i), {20'd0, prev}, {20'd0, tbl[i].wb});
        check($sformatf("dir%0d_len", i), cyc, tbl[i].len);
        check($sformatf("dir%0d_memc", i), memc, tbl[i].memc);
      end
    end

    // reset asserted in the middle of EXECUTE
    run_cycle(4'd8, 4'd8, 4'd0, 1'b0, v);
    run_cycle(4'd8, 4'd8, 4'd0, 1'b0, v);
    check("pre_rst_exec", {20'd0, v}, 32'h040);
    reset_task("rst_mid_exec");
    run_cycle(4'd8, 4'd8, 4'd0, 1'b0, v);
    check("fetch_after_rst_exec", {20'd0, v}, 32'hC00);

    // reset asserted while LOD holds its read strobe
    run_cycle(4'd1, 4'd0, 4'd0, 1'b0, v);
    run_cycle(4'd1, 4'd0, 4'd0, 1'b0, v);
    run_cycle(4'd1, 4'd0, 4'd0, 1'b0, v);
    check("lod_mem_strobe", {20'd0, v}, 32'h020);
    reset_task("rst_mid_mem");
    run_cycle(4'd1, 4'd0, 4'd0, 1'b1, v);
    check("fetch_after_rst_mem", {20'd0, v}, 32'hC00);

    // STR with memory never ready
    run_cycle(4'd2, 4'd0, 4'd0, 1'b0, v);
    run_cycle(4'd2, 4'd0, 4'd0, 1'b0, v);
    check("str_exec", {20'd0, v}, 32'h080);
    n = 0;
    run_cycle(4'd2, 4'd0, 4'd0, 1'b0, v);
    while (v[4] && n < 40) begin
      n++;
      run_cycle(4'd2, 4'd0, 4'd0, 1'b0, v);
    end
    check("timeout_waits", n, 32'd15);
    check("timeout_halt", {20'd0, v}, 32'h003);
    for (int i = 0; i < 20; i++) begin
      run_cycle(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), v);
      check("halt_hold", {20'd0, v}, 32'h003);
    end
    reset_task("rst_clears_err");
    run_cycle(4'd2, 4'd0, 4'd0, 1'b0, v);
    check("fetch_after_err", {20'd0, v}, 32'hC00);

    // HLT instruction
    run_cycle(4'd15, 4'd0, 4'd0, 1'b0, v);
    check("hlt_decode", {20'd0, v}, 32'h000);
    for (int i = 0; i < 5; i++) begin
      run_cycle(4'd15, 4'd0, 4'($urandom), 1'($urandom), v);
      check("hlt_halted", {20'd0, v}, 32'h002);
    end
    reset_task("rst_after_hlt");

    // randomized instruction stream
    for (int it = 0; it < 150; it++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(0, 15));
      mm = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
      r  = $urandom_range(0, 19);
      if (r == 0) k = 15;
      else if (r == 1) k = 14;
      else if (r == 2) k = $urandom_range(4, 13);
      else k = $urandom_range(0, 3);
      gen_instr(op, mm, k, halts);
      while (q.size() > 0) begin
        cyc_t c;
        c = q.pop_front();
        run_cycle(c.op, c.mm, c.st, c.rdy, v);
        check($sformatf("rand_op%0d", c.op), {20'd0, v}, {20'd0, c.exp});
      end
      if (halts) reset_task("rst_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
